traffic_light_ctrl: RTL and testbench

Phase sequencer for the traffic-light datapath. It drives the phase counter's `en`/`init` inputs, consumes its `last` flag and decodes the lamp outputs. It also adds two features: a pedestrian request that shortens green after a minimum dwell, and a night mode with flashing yellow. It sits between the 1 Hz tick generator and the phase counter (`pGREEN_INIT_VAL=14`, `pYELLOW_INIT_VAL=2`, `pRED_INIT_VAL=17`).

---
 rtl/traffic_light_ctrl_if.sv | 41 ++++
 rtl/traffic_light_ctrl.sv | 152 +++++++++++++++
 tb/tb_traffic_light_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/traffic_light_ctrl_if.sv
// Signal bundle between the traffic-light phase sequencer and its
// surroundings: the 1 Hz tick, the phase counter handshake (en/init/last),
// the pedestrian and night-mode inputs, and the decoded lamp outputs.
// The master modport is the sequencer's view; slave is the environment's.
interface traffic_light_ctrl_if #(
    parameter int pINIT_WIDTH = 3
);
    logic                   tick;
    logic                   cnt_last;
    logic                   ped_req;
    logic                   night_mode;
    logic                   cnt_en;
    logic [pINIT_WIDTH-1:0] cnt_init;
    logic [2:0]             light;
    logic                   ped_walk;
    logic                   ped_pending;

    modport master (
        input  tick,
        input  cnt_last,
        input  ped_req,
        input  night_mode,
        output cnt_en,
        output cnt_init,
        output light,
        output ped_walk,
        output ped_pending
    );

    modport slave (
        output tick,
        output cnt_last,
        output ped_req,
        output night_mode,
        input  cnt_en,
        input  cnt_init,
        input  light,
        input  ped_walk,
        input  ped_pending
    );
endinterface

// File: rtl/traffic_light_ctrl.sv
// Traffic-light phase sequencer. Steps GREEN -> YELLOW -> RED -> GREEN on the
// phase counter's last flag, reloading the counter with the next phase's
// one-hot init on the same edge the state changes. A latched pedestrian
// request can cut green short once a minimum dwell has elapsed, and night
// mode diverts the RED exit into a flashing-yellow FLASH state.
module traffic_light_ctrl #(
    parameter int pINIT_WIDTH = 3,
    parameter int pMIN_GREEN  = 4,
    parameter int pGT_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    traffic_light_ctrl_if.master  bus
);

    typedef enum logic [1:0] {
        GREEN  = 2'd0,
        YELLOW = 2'd1,
        RED    = 2'd2,
        FLASH  = 2'd3
    } state_t;

    // One-hot counter reload codes: bit 0 green, bit 1 yellow, bit 2 red.
    localparam logic [pINIT_WIDTH-1:0] INIT_GREEN  = pINIT_WIDTH'(1);
    localparam logic [pINIT_WIDTH-1:0] INIT_YELLOW = pINIT_WIDTH'(2);
    localparam logic [pINIT_WIDTH-1:0] INIT_RED    = pINIT_WIDTH'(4);

    // Dwell threshold in the counter's width, and one bit wider so that the
    // "dwell + 1" comparison cannot wrap.
    localparam logic [pGT_WIDTH-1:0] MIN_GREEN_N = pGT_WIDTH'(pMIN_GREEN);
    localparam logic [pGT_WIDTH:0]   MIN_GREEN_W = (pGT_WIDTH + 1)'(pMIN_GREEN);
    localparam logic [pGT_WIDTH-1:0] ONE_N       = pGT_WIDTH'(1);
    localparam logic [pGT_WIDTH:0]   ONE_W       = (pGT_WIDTH + 1)'(1);

    state_t                 state_q;
    state_t                 state_d;
    logic [pGT_WIDTH-1:0]   dwell_q;
    logic [pGT_WIDTH-1:0]   dwell_d;
    logic                   pend_q;
    logic                   pend_d;
    logic                   flash_q;
    logic                   flash_d;

    logic [pGT_WIDTH:0]     dwell_inc;
    logic                   early_exit;
    logic                   cnt_en_c;
    logic [pINIT_WIDTH-1:0] cnt_init_c;
    logic [2:0]             light_c;

    // A pending pedestrian may end green once the dwell including this tick
    // reaches the minimum.
    assign dwell_inc  = {1'b0, dwell_q} + ONE_W;
    assign early_exit = pend_q && (dwell_inc >= MIN_GREEN_W);

    // State, dwell, pedestrian latch and flash phase registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= GREEN;
            dwell_q <= '0;
            pend_q  <= 1'b0;
            flash_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dwell_q <= dwell_d;
            pend_q  <= pend_d;
            flash_q <= flash_d;
        end
    end

    // Next-state logic and counter handshake; nothing moves without a tick
    // except the pedestrian latch.
    always_comb begin
        state_d    = state_q;
        dwell_d    = dwell_q;
        pend_d     = pend_q;
        flash_d    = flash_q;
        cnt_en_c   = 1'b0;
        cnt_init_c = '0;

        if (bus.ped_req && (state_q == GREEN || state_q == YELLOW)) begin
            pend_d = 1'b1;
        end

        if (bus.tick) begin
            case (state_q)
                GREEN: begin
                    cnt_en_c = 1'b1;
                    if (bus.cnt_last || early_exit) begin
                        state_d    = YELLOW;
                        cnt_init_c = INIT_YELLOW;
                    end else if (dwell_q < MIN_GREEN_N) begin
                        dwell_d = dwell_q + ONE_N;
                    end
                end
                YELLOW: begin
                    cnt_en_c = 1'b1;
                    if (bus.cnt_last) begin
                        state_d    = RED;
                        cnt_init_c = INIT_RED;
                        pend_d     = 1'b0;
                    end
                end
                RED: begin
                    if (bus.cnt_last && bus.night_mode) begin
                        state_d = FLASH;
                        flash_d = 1'b1;
                        pend_d  = 1'b0;
                    end else if (bus.cnt_last) begin
                        cnt_en_c   = 1'b1;
                        state_d    = GREEN;
                        cnt_init_c = INIT_GREEN;
                        dwell_d    = '0;
                    end else begin
                        cnt_en_c = 1'b1;
                    end
                end
                FLASH: begin
                    if (!bus.night_mode) begin
                        cnt_en_c   = 1'b1;
                        state_d    = RED;
                        cnt_init_c = INIT_RED;
                        pend_d     = 1'b0;
                    end else begin
                        flash_d = ~flash_q;
                    end
                end
                default: begin
                    state_d = GREEN;
                end
            endcase
        end
    end

    // Moore lamp decode; FLASH shows yellow only while the phase bit is set.
    always_comb begin
        light_c = 3'b001;
        case (state_q)
            GREEN:   light_c = 3'b001;
            YELLOW:  light_c = 3'b010;
            RED:     light_c = 3'b100;
            FLASH:   light_c = {1'b0, flash_q, 1'b0};
            default: light_c = 3'b001;
        endcase
    end

    assign bus.cnt_en      = cnt_en_c;
    assign bus.cnt_init    = cnt_init_c;
    assign bus.light       = light_c;
    assign bus.ped_walk    = (state_q == RED);
    assign bus.ped_pending = pend_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl. A small phase counter (green 14,
// yellow 2, red 17, reset loads green) closes the en/init/last loop so the
// sequencer runs its real phase lengths; expected lamp and reload values are
// hand-derived from those lengths.
module tb_traffic_light_ctrl;

    logic clk;
    logic rst_n;
    logic night_lvl;
    int   errors;
    int   checks;
    logic [4:0] cnt;

    traffic_light_ctrl_if #(.pINIT_WIDTH(3)) bus ();

    traffic_light_ctrl #(
        .pINIT_WIDTH(3),
        .pMIN_GREEN (4),
        .pGT_WIDTH  (4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // 100 MHz-style free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Phase counter the sequencer drives: reload on a one-hot init, else count down.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 5'd14;
        end else if (bus.cnt_en) begin
            if (bus.cnt_init[0])      cnt <= 5'd14;
            else if (bus.cnt_init[1]) cnt <= 5'd2;
            else if (bus.cnt_init[2]) cnt <= 5'd17;
            else                      cnt <= cnt - 5'd1;
        end
    end
    assign bus.cnt_last = (cnt == 5'd0);

    // Drive inputs just after a falling edge, then let combinational outputs settle.
    task automatic applyStimulus(input logic t, input logic p, input logic n);
        @(negedge clk);
        bus.tick       = t;
        bus.ped_req    = p;
        bus.night_mode = n;
        #1;
    endtask

    // One comparison: counts it, and counts and reports a failure.
    task automatic checkOutput(input string tag, input logic [2:0] observed, input logic [2:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    // One tick with its handshake checked, then three quiet clocks.
    task automatic doTick(input logic p, input logic exp_en, input logic [2:0] exp_init, input string tag);
        applyStimulus(1'b1, p, night_lvl);
        checkOutput({tag, ".cnt_en"},   {2'b00, bus.cnt_en}, {2'b00, exp_en});
        checkOutput({tag, ".cnt_init"}, bus.cnt_init, exp_init);
        applyStimulus(1'b0, 1'b0, night_lvl);
        checkOutput({tag, ".idle_en"}, {2'b00, bus.cnt_en}, 3'b000);
        applyStimulus(1'b0, 1'b0, night_lvl);
        applyStimulus(1'b0, 1'b0, night_lvl);
    endtask

    // Lamp and walk state after a tick.
    task automatic checkLamps(input logic [2:0] exp_light, input logic exp_walk, input string tag);
        checkOutput({tag, ".light"},    bus.light, exp_light);
        checkOutput({tag, ".ped_walk"}, {2'b00, bus.ped_walk}, {2'b00, exp_walk});
    endtask

    // n mid-phase ticks: plain decrement, lamp unchanged.
    task automatic runTicks(input int n, input logic [2:0] exp_light, input string tag);
        for (int i = 0; i < n; i++) begin
            doTick(1'b0, 1'b1, 3'b000, $sformatf("%s[%0d]", tag, i));
            checkLamps(exp_light, exp_light == 3'b100, $sformatf("%s[%0d]", tag, i));
        end
    endtask

    // Time limit so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        errors         = 0;
        checks         = 0;
        night_lvl      = 1'b0;
        rst_n          = 1'b0;
        bus.tick       = 1'b0;
        bus.ped_req    = 1'b0;
        bus.night_mode = 1'b0;

        // Reset values.
        repeat (2) @(negedge clk);
        #1;
        checkLamps(3'b001, 1'b0, "rst");
        checkOutput("rst.ped_pending", {2'b00, bus.ped_pending}, 3'b000);
        checkOutput("rst.cnt_en",      {2'b00, bus.cnt_en}, 3'b000);
        checkOutput("rst.cnt_init",    bus.cnt_init, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] normal cycle");
        runTicks(14, 3'b001, "n.green");
        doTick(1'b0, 1'b1, 3'b010, "n.g2y");
        checkLamps(3'b010, 1'b0, "n.g2y");
        runTicks(2, 3'b010, "n.yellow");
        doTick(1'b0, 1'b1, 3'b100, "n.y2r");
        checkLamps(3'b100, 1'b1, "n.y2r");
        runTicks(17, 3'b100, "n.red");
        doTick(1'b0, 1'b1, 3'b001, "n.r2g");
        checkLamps(3'b001, 1'b0, "n.r2g");

        $display("[TB] pedestrian early exit");
        doTick(1'b1, 1'b1, 3'b000, "p.t1");
        checkOutput("p.t1.pending", {2'b00, bus.ped_pending}, 3'b001);
        checkLamps(3'b001, 1'b0, "p.t1");
        runTicks(2, 3'b001, "p.green");
        doTick(1'b0, 1'b1, 3'b010, "p.t4");
        checkLamps(3'b010, 1'b0, "p.t4");
        checkOutput("p.t4.pending", {2'b00, bus.ped_pending}, 3'b001);
        runTicks(2, 3'b010, "p.yellow");
        doTick(1'b0, 1'b1, 3'b100, "p.y2r");
        checkLamps(3'b100, 1'b1, "p.y2r");
        checkOutput("p.red.pending", {2'b00, bus.ped_pending}, 3'b000);
        runTicks(17, 3'b100, "p.red");
        doTick(1'b0, 1'b1, 3'b001, "p.r2g");
        checkLamps(3'b001, 1'b0, "p.r2g");

        $display("[TB] pedestrian on green last tick");
        runTicks(14, 3'b001, "s.green");
        doTick(1'b1, 1'b1, 3'b010, "s.g2y");
        checkLamps(3'b010, 1'b0, "s.g2y");
        checkOutput("s.g2y.pending", {2'b00, bus.ped_pending}, 3'b001);
        runTicks(2, 3'b010, "s.yellow");
        doTick(1'b0, 1'b1, 3'b100, "s.y2r");
        checkLamps(3'b100, 1'b1, "s.y2r");
        checkOutput("s.red.pending", {2'b00, bus.ped_pending}, 3'b000);
        runTicks(17, 3'b100, "s.red");
        doTick(1'b0, 1'b1, 3'b001, "s.r2g");
        checkLamps(3'b001, 1'b0, "s.r2g");

        $display("[TB] night mode");
        runTicks(5, 3'b001, "f.green_a");
        night_lvl = 1'b1;
        runTicks(9, 3'b001, "f.green_b");
        doTick(1'b0, 1'b1, 3'b010, "f.g2y");
        checkLamps(3'b010, 1'b0, "f.g2y");
        runTicks(2, 3'b010, "f.yellow");
        doTick(1'b0, 1'b1, 3'b100, "f.y2r");
        checkLamps(3'b100, 1'b1, "f.y2r");
        doTick(1'b1, 1'b1, 3'b000, "f.red_ped");
        checkOutput("f.red_ped.pending", {2'b00, bus.ped_pending}, 3'b000);
        runTicks(16, 3'b100, "f.red");
        doTick(1'b0, 1'b0, 3'b000, "f.r2f");
        checkLamps(3'b010, 1'b0, "f.r2f");
        doTick(1'b1, 1'b0, 3'b000, "f.off");
        checkLamps(3'b000, 1'b0, "f.off");
        checkOutput("f.off.pending", {2'b00, bus.ped_pending}, 3'b000);
        doTick(1'b0, 1'b0, 3'b000, "f.on");
        checkLamps(3'b010, 1'b0, "f.on");
        night_lvl = 1'b0;
        doTick(1'b0, 1'b1, 3'b100, "f.f2r");
        checkLamps(3'b100, 1'b1, "f.f2r");
        runTicks(17, 3'b100, "f.red2");
        doTick(1'b0, 1'b1, 3'b001, "f.r2g");
        checkLamps(3'b001, 1'b0, "f.r2g");

        $display("[TB] reset mid-red");
        runTicks(14, 3'b001, "r.green");
        doTick(1'b0, 1'b1, 3'b010, "r.g2y");
        runTicks(2, 3'b010, "r.yellow");
        doTick(1'b0, 1'b1, 3'b100, "r.y2r");
        runTicks(5, 3'b100, "r.red");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkLamps(3'b001, 1'b0, "r.async");
        checkOutput("r.async.pending", {2'b00, bus.ped_pending}, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        runTicks(14, 3'b001, "r.green2");
        doTick(1'b0, 1'b1, 3'b010, "r.g2y2");
        checkLamps(3'b010, 1'b0, "r.g2y2");

        $display("[TB] no tick for 100 cycles");
        for (int i = 0; i < 100; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            checkOutput($sformatf("q[%0d].cnt_en", i), {2'b00, bus.cnt_en}, 3'b000);
            checkOutput($sformatf("q[%0d].light", i), bus.light, 3'b010);
        end
        checkOutput("q.ped_walk", {2'b00, bus.ped_walk}, 3'b000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
